axis_boxcar_decimator: RTL and testbench

AXIS_BOXCAR_DECIMATOR -- requirements
Module: axis_boxcar_decimator

---
 rtl/axis_boxcar_decimator.sv | 95 +++++++++
 tb/tb_axis_boxcar_decimator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_boxcar_decimator.sv
// axis_boxcar_decimator
//   Boxcar (moving-block mean) decimator on an AXI-Stream-style sample link.
//   Every N = 2**log2_decim accepted input samples are summed and the sum is
//   arithmetically shifted right by log2_decim to form one output sample.
//
// Parameters
//   inout_width : signed sample width on both input and output
//   log2_decim  : decimation exponent, N = 2**log2_decim (1..8)
//
// Ports
//   clk            : clock, all logic on rising edge
//   rst            : synchronous active-high reset
//   s_axis_tdata   : signed input sample
//   s_axis_tvalid  : input sample valid
//   s_axis_tready  : block can accept an input sample
//   m_axis_tdata   : signed decimated output sample
//   m_axis_tvalid  : output sample valid
//   m_axis_tready  : downstream ready
//
// Build option
//   BOXCAR_ROUND_EN : when defined, 2**(log2_decim-1) is added to the block
//                     sum before the shift (round half toward +inf); otherwise
//                     the plain arithmetic shift (floor) is used.

module axis_boxcar_decimator #(
  parameter int inout_width = 16,
  parameter int log2_decim  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [inout_width-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  // N in-range samples need log2_decim guard bits, so the sum cannot overflow.
  localparam int acc_width = inout_width + log2_decim;

  logic signed [acc_width-1:0]   acc;
  logic signed [acc_width-1:0]   sample_ext;
  logic signed [acc_width-1:0]   sum_full;
  logic signed [acc_width-1:0]   sum_final;
  logic signed [acc_width-1:0]   mean;
  logic        [log2_decim-1:0]  cnt;
  logic                          accept;
  logic                          last;

  // Input stalls only while an output is waiting on a blocked downstream.
  assign s_axis_tready = ~(m_axis_tvalid & ~m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign last          = &cnt;

  assign sample_ext = {{log2_decim{s_axis_tdata[inout_width-1]}}, s_axis_tdata};
  assign sum_full   = acc + sample_ext;

`ifdef BOXCAR_ROUND_EN
  localparam logic signed [acc_width-1:0] round_const = acc_width'(1) << (log2_decim - 1);
  assign sum_final = sum_full + round_const;
`else
  assign sum_final = sum_full;
`endif

  // Mean of N in-range samples is itself in range, so truncation is exact.
  assign mean = sum_final >>> log2_decim;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      // A block completing on the same edge as a handshake reloads the
      // output, so valid stays high with no bubble.
      if (accept) begin
        if (last) begin
          m_axis_tdata  <= mean[inout_width-1:0];
          m_axis_tvalid <= 1'b1;
          acc           <= '0;
          cnt           <= '0;
        end else begin
          acc <= sum_full;
          cnt <= cnt + log2_decim'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_boxcar_decimator.sv
// tb_axis_boxcar_decimator
//   Directed-vector bench for axis_boxcar_decimator (default parameters).
//   Expected outputs are queued when stimulus is issued; a monitor pops and
//   compares on every output handshake. Inputs change 1 time unit after the
//   rising edge; the monitor samples on the falling edge.

module tb_axis_boxcar_decimator;

  logic        clk;
  logic        rst;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  int checks;
  int errors;
  int accepts;
  int base;

  int exp_q[$];

  logic        prev_stalled;
  logic [15:0] held_data;

  axis_boxcar_decimator #(
    .inout_width (16),
    .log2_decim  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: handshake -> compare against scoreboard; stall -> data must hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stalled = 1'b0;
    end else begin
      if (s_tvalid && s_tready) accepts++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", $signed(m_tdata));
        end else begin
          check("output_data", int'($signed(m_tdata)), exp_q.pop_front());
        end
      end
      if (m_tvalid && !m_tready) begin
        if (prev_stalled) check("hold_data", int'($signed(m_tdata)), int'($signed(held_data)));
        held_data    = m_tdata;
        prev_stalled = 1'b1;
      end else begin
        prev_stalled = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d);
    int waits;
    s_tdata  = 16'(d);
    s_tvalid = 1'b1;
    waits    = 0;
    while (!s_tready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_axis_tready 0 expected 1 within 50 cycles");
      s_tvalid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    accepts      = 0;
    prev_stalled = 1'b0;
    held_data    = '0;
    rst          = 1'b1;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    m_tready     = 1'b1;

    // Reset held for 5 cycles.
    repeat (5) begin
      @(posedge clk); #1;
      check("reset_tvalid", int'(m_tvalid), 0);
      check("reset_tdata", int'(m_tdata), 0);
    end
    rst = 1'b0;
    #1 check("tready_after_reset", int'(s_tready), 1);

    // Basic mean, one-cycle valid pulse.
    exp_q.push_back(250);
    send4(100, 200, 300, 400);
    s_tvalid = 1'b0;
    check("valid_after_4th", int'(m_tvalid), 1);
    @(posedge clk); #1;
    check("valid_one_cycle", int'(m_tvalid), 0);

    // Negative sums: floor versus round half up.
`ifdef BOXCAR_ROUND_EN
    exp_q.push_back(-1);
    exp_q.push_back(3);
    exp_q.push_back(-3);
`else
    exp_q.push_back(-2);
    exp_q.push_back(2);
    exp_q.push_back(-3);
`endif
    send4(-1, -1, -1, -2);
    send4(1, 2, 3, 5);
    send4(-3, -3, -3, -2);

    // Full-scale extremes.
    exp_q.push_back(32767);
    exp_q.push_back(-32768);
    send4(32767, 32767, 32767, 32767);
    send4(-32768, -32768, -32768, -32768);
    idle(3);
    check("queue_drained_1", exp_q.size(), 0);

    // Backpressure: output held, only 4 samples accepted while blocked.
    base = accepts;
    m_tready = 1'b0;
    exp_q.push_back(10);
    exp_q.push_back(10);
    send4(10, 10, 10, 10);
    s_tdata  = 16'd10;
    s_tvalid = 1'b1;
    #1;
    check("stall_tvalid", int'(m_tvalid), 1);
    check("stall_tready", int'(s_tready), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_tready_held", int'(s_tready), 0);
      check("stall_tdata_held", int'($signed(m_tdata)), 10);
    end
    check("stall_accept_count", accepts - base, 4);
    m_tready = 1'b1;
    #1 check("tready_on_release", int'(s_tready), 1);
    @(posedge clk); #1;
    send(10); send(10); send(10);
    idle(3);
    check("stall_total_accepts", accepts - base, 8);
    check("queue_drained_2", exp_q.size(), 0);

    // Reset discards a pending blocked output.
    m_tready = 1'b0;
    send4(5, 5, 5, 5);
    s_tvalid = 1'b0;
    check("pending_before_reset", int'(m_tvalid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("pending_cleared_tvalid", int'(m_tvalid), 0);
    check("pending_cleared_tdata", int'(m_tdata), 0);
    rst = 1'b0;
    m_tready = 1'b1;

    // Reset discards a partial block.
    exp_q.push_back(8);
    send(7); send(9);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send4(8, 8, 8, 8);
    idle(5);
    check("queue_drained_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
